// File: rtl/filter_cfg_pkg.sv
// filter_cfg_pkg: shared widths, FSM state encoding and committed-config record
//   FILTER_W / FREQ_W : default widths of filter_num / freq_flag
//   cfg_state_t       : sequencer states
//   cfg_t             : {filter_num, freq_flag} pair as seen by the datapath
package filter_cfg_pkg;
    localparam int FILTER_W = 2;
    localparam int FREQ_W   = 2;
    typedef enum logic [1:0] {IDLE, WAIT_VS, APPLY, SETTLE} cfg_state_t;
    typedef struct packed {
        logic [FILTER_W-1:0] filter_num;
        logic [FREQ_W-1:0]   freq_flag;
    } cfg_t;
endpackage

// File: rtl/filter_cfg_ctrl_sync_debounce.sv
// sync_debounce: 2-flop synchroniser plus stability counter for a raw input bus
//   clk, reset : clock, asynchronous active-high reset
//   din        : raw asynchronous input bus
//   dout       : value accepted after CYCLES cycles without change (resets to INIT)
module sync_debounce #(
    parameter int               WIDTH  = 1,
    parameter int               CYCLES = 4,
    parameter logic [WIDTH-1:0] INIT   = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);
    logic [WIDTH-1:0] s1, s2, prev;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1   <= '1;
            s2   <= '1;
            prev <= '1;
            cnt  <= '0;
            dout <= INIT;
        end else begin
            s1   <= din;
            s2   <= s1;
            prev <= s2;
            // counter saturates at LAST so a long-stable value keeps being accepted
            cnt  <= (s2 != prev) ? '0 : (cnt == LAST) ? cnt : cnt + 1'b1;
            if (s2 == prev && cnt == LAST) dout <= s2;
        end
    end
endmodule

// File: rtl/filter_cfg_ctrl.sv
// filter_cfg_ctrl: conditions board controls and commits {filter_num, freq_flag} on vsync falls
//   clk, reset   : 50 MHz clock, asynchronous active-high reset
//   sw_filter    : raw filter-select switches
//   sw_freq      : raw frequency-select switches
//   key_next_n   : raw active-low push-button, each press advances the filter offset
//   vga_vs       : VGA vertical sync (active-low), frame boundary reference
//   filter_num   : committed filter select
//   freq_flag    : committed frequency select
//   cfg_strobe   : one-cycle pulse on the cycle the outputs change
//   busy         : high whenever the sequencer is not IDLE
module filter_cfg_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SETTLE_CYCLES   = 16,
    parameter int FILTER_W        = filter_cfg_pkg::FILTER_W,
    parameter int FREQ_W          = filter_cfg_pkg::FREQ_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [FILTER_W-1:0] sw_filter,
    input  logic [FREQ_W-1:0]   sw_freq,
    input  logic                key_next_n,
    input  logic                vga_vs,
    output logic [FILTER_W-1:0] filter_num,
    output logic [FREQ_W-1:0]   freq_flag,
    output logic                cfg_strobe,
    output logic                busy
);
    import filter_cfg_pkg::*;
    localparam int SW_W = FILTER_W + FREQ_W;
    localparam int SCW  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);
    cfg_state_t state, state_nx;
    logic [SW_W-1:0] sw_stable;
    logic key_stable, key_prev;
    logic [FILTER_W-1:0] offset, filter_tgt;
    logic [FREQ_W-1:0] freq_tgt;
    logic vs_s1, vs_s2, vs_prev, vs_fall, differs;
    logic [SCW-1:0] settle_cnt;

    sync_debounce #(.WIDTH(SW_W), .CYCLES(DEBOUNCE_CYCLES)) u_sw (
        .clk(clk), .reset(reset), .din({sw_freq, sw_filter}), .dout(sw_stable)
    );
    // key idles high, so its accepted value starts released
    sync_debounce #(.WIDTH(1), .CYCLES(DEBOUNCE_CYCLES), .INIT(1'b1)) u_key (
        .clk(clk), .reset(reset), .din(key_next_n), .dout(key_stable)
    );

    assign filter_tgt = sw_stable[FILTER_W-1:0] + offset;
    assign freq_tgt   = sw_stable[SW_W-1:FILTER_W];
    assign vs_fall    = vs_prev & ~vs_s2;
    assign differs    = {filter_tgt, freq_tgt} != {filter_num, freq_flag};
    assign busy       = state != IDLE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // a fall seen in IDLE is ignored: the change must wait a full frame in WAIT_VS
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = differs ? WAIT_VS : IDLE;
            WAIT_VS: state_nx = !differs ? IDLE : vs_fall ? APPLY : WAIT_VS;
            APPLY:   state_nx = SETTLE;
            SETTLE:  state_nx = (settle_cnt == SETTLE_LAST) ? IDLE : SETTLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vs_s1      <= 1'b1;
            vs_s2      <= 1'b1;
            vs_prev    <= 1'b1;
            key_prev   <= 1'b1;
            offset     <= '0;
            settle_cnt <= '0;
            filter_num <= '0;
            freq_flag  <= '0;
            cfg_strobe <= 1'b0;
        end else begin
            vs_s1      <= vga_vs;
            vs_s2      <= vs_s1;
            vs_prev    <= vs_s2;
            key_prev   <= key_stable;
            if (key_prev && !key_stable) offset <= offset + 1'b1;
            settle_cnt <= (state == SETTLE) ? settle_cnt + 1'b1 : '0;
            cfg_strobe <= state == APPLY;
            if (state == APPLY) begin
                filter_num <= filter_tgt;
                freq_flag  <= freq_tgt;
            end
        end
    end
endmodule
